cpy_alu_driver: RTL and testbench

Command-side initiator for the milestone-1 registered ALU. It accepts an operation request over a valid/ready handshake, drives the ALU's opA/opB/sel inputs for exactly one sampling edge, and captures the registered result and z/c/v flags after the ALU's one-cycle latency. It then returns them over a valid/ready response channel. Unsupported opcodes are rejected locally and never issued to the ALU.

---
 rtl/cpy_alu_pkg.sv | 16 +
 rtl/cpy_alu_driver.sv | 136 +++++++++++++
 tb/tb_cpy_alu_driver.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpy_alu_pkg.sv
// Shared opcode constants and helpers for the registered ALU
// and its command-side driver.
package cpy_alu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/cpy_alu_driver.sv
// Command-side initiator for the registered ALU: issues one op,
// waits out the ALU latency, returns result/flags on a response port.
module cpy_alu_driver
    import cpy_alu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = 1
) (
    input  logic              elk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_opA,
    output logic [DATA_W-1:0] alu_opB,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_z,
    output logic              rsp_c,
    output logic              rsp_v,
    output logic              rsp_err,
    output logic [15:0]       op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_wait;
    logic              r_cmd_ready;
    logic [2:0]        r_sel;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_res;
    logic              r_rsp_z;
    logic              r_rsp_c;
    logic              r_rsp_v;
    logic              r_rsp_err;
    logic [15:0]       r_op_count;

    always_ff @(posedge elk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_cmd_ready <= 1'b0;
            r_sel       <= OP_NOP;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_c     <= 1'b0;
            r_rsp_v     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        if (is_legal_op(cmd_op)) begin
                            r_opA   <= cmd_a;
                            r_opB   <= cmd_b;
                            r_sel   <= cmd_op;
                            r_state <= S_ISSUE;
                        end else begin
                            // rejected locally; the ALU never sees it
                            r_rsp_err   <= 1'b1;
                            r_rsp_res   <= '0;
                            r_rsp_z     <= 1'b0;
                            r_rsp_c     <= 1'b0;
                            r_rsp_v     <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_sel   <= OP_NOP;
                    r_wait  <= CW'(WAIT_CYC - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_rsp_res   <= alu_res;
                        r_rsp_z     <= alu_z;
                        r_rsp_c     <= alu_c;
                        r_rsp_v     <= alu_v;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait <= r_wait - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_sel   = r_sel;
    assign alu_opA   = r_opA;
    assign alu_opB   = r_opB;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_z     = r_rsp_z;
    assign rsp_c     = r_rsp_c;
    assign rsp_v     = r_rsp_v;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_cpy_alu_driver.sv
// Self-checking bench for cpy_alu_driver with a stand-in ALU
// whose c/v flags are made distinguishable to expose pass-through.
module tb_cpy_alu_driver;
    import cpy_alu_pkg::*;

    localparam int W = 32;

    logic         elk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'b000;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_opA;
    logic [W-1:0] alu_opB;
    logic [W-1:0] alu_res = '0;
    logic         alu_z = 1'b0;
    logic         alu_c = 1'b0;
    logic         alu_v = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_res;
    logic         rsp_z;
    logic         rsp_c;
    logic         rsp_v;
    logic         rsp_err;
    logic [15:0]  op_count;

    cpy_alu_driver #(.DATA_W(W), .WAIT_CYC(1)) dut (
        .elk(elk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_sel(alu_sel), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_res(alu_res), .alu_z(alu_z),
        .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_z(rsp_z),
        .rsp_c(rsp_c), .rsp_v(rsp_v),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 elk = ~elk;

    // stand-in registered ALU: sel=000 holds; c=res[31], v=res[0]
    always @(posedge elk) begin
        logic [W-1:0] r;
        if (alu_sel != OP_NOP) begin
            case (alu_sel)
                OP_AND:  r = alu_opA & alu_opB;
                OP_OR:   r = alu_opA | alu_opB;
                OP_NOT:  r = ~alu_opA;
                default: r = 32'hDEAD_BEEF;
            endcase
            alu_res <= r;
            alu_z   <= (r == '0);
            alu_c   <= r[W-1];
            alu_v   <= r[0];
        end
    end

    int sel_edges = 0;
    always @(posedge elk) begin
        if (alu_sel != OP_NOP) sel_edges++;
    end

    int total = 0;
    int bad = 0;
    logic [15:0] exp_cnt = 16'h0;

    task automatic chk(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // {err, z, c, v, res} from the opcode semantics
    function automatic logic [W+3:0] ref_op(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        if (op == 3'b010)      r = a & b;
        else if (op == 3'b011) r = a | b;
        else if (op == 3'b100) r = ~a;
        else return {1'b1, 3'b000, {W{1'b0}}};
        return {1'b0, (r == 0), r[W-1], r[0], r};
    endfunction

    task automatic do_op(input logic [2:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] eres,
                         input logic ez, input logic ec,
                         input logic ev, input logic eerr,
                         input int hold);
        int n;
        int lat;
        sel_edges = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge elk); #1; n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge elk); #1;
        cmd_valid = 1'b0;
        if (!eerr) chk("opA_load", alu_opA, a);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge elk); #1; lat++;
        end
        chk("latency", 32'(lat), eerr ? 32'd0 : 32'd2);
        chk("rsp_res", rsp_res, eres);
        chk("rsp_z", 32'(rsp_z), 32'(ez));
        chk("rsp_c", 32'(rsp_c), 32'(ec));
        chk("rsp_v", 32'(rsp_v), 32'(ev));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        // stall while offering a competing command
        cmd_op    = 3'b011;
        cmd_a     = ~a;
        cmd_b     = b ^ 32'h5A5A_5A5A;
        cmd_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge elk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_res", rsp_res, eres);
            chk("bp_err", 32'(rsp_err), 32'(eerr));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge elk); #1;
        rsp_ready = 1'b0;
        if (!eerr) exp_cnt = exp_cnt + 16'd1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("sel_edges", 32'(sel_edges), eerr ? 32'd0 : 32'd1);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [W+3:0] e;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        tbl[0] = '{3'b010, 32'hF0F0_00FF, 32'h0F0F_00F0,
                   32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'b100, 32'hFFFF_FFFF, 32'h1234_5678,
                   32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{3'b011, 32'h0000_0000, 32'h0000_0000,
                   32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3'b111, 32'h0000_0005, 32'h0000_0000,
                   32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{3'b011, 32'h0000_00F0, 32'h0000_000F,
                   32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{3'b100, 32'h0000_0000, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{3'b000, 32'hAAAA_AAAA, 32'h5555_5555,
                   32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};

        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_sel", 32'(alu_sel), 32'd0);
        chk("rst_opA", alu_opA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge elk);
        #1;
        rst = 1'b0;
        chk("ready_pre_edge", 32'(cmd_ready), 32'd0);
        @(posedge elk); #1;
        chk("ready_first_edge", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                  tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].err, 0);

        // backpressure: 10 stalled cycles, then normal traffic
        do_op(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].res,
              tbl[0].z, tbl[0].c, tbl[0].v, tbl[0].err, 10);
        do_op(tbl[4].op, tbl[4].a, tbl[4].b, tbl[4].res,
              tbl[4].z, tbl[4].c, tbl[4].v, tbl[4].err, 0);

        // reset while waiting on the ALU
        cmd_op = OP_AND;
        cmd_a  = 32'hFFFF_0000;
        cmd_b  = 32'h00FF_FF00;
        cmd_valid = 1'b1;
        @(posedge elk); #1;
        cmd_valid = 1'b0;
        @(posedge elk); #1;
        rst = 1'b1;
        #1;
        exp_cnt = 16'h0;
        chk("mid_rst_sel", 32'(alu_sel), 32'd0);
        chk("mid_rst_opA", alu_opA, 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge elk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge elk); #1;
            if (rsp_valid) seen = 1;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        do_op(tbl[5].op, tbl[5].a, tbl[5].b, tbl[5].res,
              tbl[5].z, tbl[5].c, tbl[5].v, tbl[5].err, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 0) rb = ~ra;
            e = ref_op(rop, ra, rb);
            do_op(rop, ra, rb, e[W-1:0], e[W+2], e[W+1],
                  e[W], e[W+3], $urandom_range(0, 3));
        end

        // preload the counter just below wrap
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        #1;
        exp_cnt = 16'hFFFF;
        chk("preload", 32'(op_count), 32'h0000_FFFF);
        do_op(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].res,
              tbl[0].z, tbl[0].c, tbl[0].v, tbl[0].err, 0);
        chk("wrap_zero", 32'(op_count), 32'd0);
        do_op(tbl[3].op, tbl[3].a, tbl[3].b, tbl[3].res,
              tbl[3].z, tbl[3].c, tbl[3].v, tbl[3].err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
